// File: rtl/soc_ctrl_domain_seq.sv
// soc_ctrl_domain_seq: N-domain clock-enable / reset sequencer.
// Per-domain PLL-lock wait, timeout, lock-loss recovery and ordering.
module soc_ctrl_domain_seq #(
  parameter int NUM_DOMAINS = 5,
  parameter int CNT_W       = 8,
  parameter int LOCK_TO_CYC = 1024,
  parameter bit ORDERED     = 1'b1
) (
  input  logic                         clk_i,
  input  logic                         arst_i,
  input  logic [NUM_DOMAINS-1:0]       dom_req_i,
  input  logic [NUM_DOMAINS*CNT_W-1:0] dom_dly_i,
  input  logic [NUM_DOMAINS-1:0]       pll_locked_i,
  output logic [NUM_DOMAINS-1:0]       dom_clk_en_o,
  output logic [NUM_DOMAINS-1:0]       dom_arst_n_o,
  output logic [NUM_DOMAINS*3-1:0]     dom_state_o,
  output logic [NUM_DOMAINS-1:0]       dom_err_o,
  output logic [NUM_DOMAINS-1:0]       lock_lost_o,
  output logic                         busy_o
);

  localparam int TO_W = $clog2(LOCK_TO_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST =
    TO_W'(LOCK_TO_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    S_OFF       = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_CLK_ON    = 3'd2,
    S_RUN       = 3'd3,
    S_RST_ON    = 3'd4,
    S_ERR       = 3'd5
  } st_e;

  // Registered state of every domain, packed for neighbour lookups.
  logic [NUM_DOMAINS*3-1:0] st_all;
  // Next-state transitional flags, used to register busy.
  logic [NUM_DOMAINS-1:0]   busy_vec;
  logic                     busy_q;

  for (genvar g = 0; g < NUM_DOMAINS; g++) begin : g_dom
    logic             lk_s1_q;
    logic             lk_s2_q;
    st_e              s_q;
    st_e              s_d;
    logic [CNT_W-1:0] dly_in;
    logic [CNT_W-1:0] dly_eff;
    logic [CNT_W-1:0] dly_q;
    logic [CNT_W-1:0] dly_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [TO_W-1:0]  to_q;
    logic [TO_W-1:0]  to_d;
    logic             err_q;
    logic             err_d;
    logic             lost_q;
    logic             lost_d;
    logic             clk_en_q;
    logic             arst_n_q;
    logic             up_ok;
    logic             down_ok;
    logic             req;
    logic             locked;
    logic             lock_drop;

    assign req     = dom_req_i[g];
    assign locked  = lk_s2_q;
    assign dly_in  = dom_dly_i[g*CNT_W +: CNT_W];
    assign dly_eff = (dly_in == '0) ? CNT_ONE : dly_in;

    // Power-up waits for the previous domain to be running.
    if (ORDERED && g > 0) begin : g_up
      assign up_ok =
        (st_all[(g-1)*3 +: 3] == S_RUN);
    end else begin : g_up_free
      assign up_ok = 1'b1;
    end

    // Power-down waits for the next domain to be off.
    if (ORDERED && g < NUM_DOMAINS - 1) begin : g_dn
      assign down_ok =
        (st_all[(g+1)*3 +: 3] == S_OFF) ||
        (st_all[(g+1)*3 +: 3] == S_ERR);
    end else begin : g_dn_free
      assign down_ok = 1'b1;
    end

    assign lock_drop = !locked &&
      ((s_q == S_CLK_ON) || (s_q == S_RUN) ||
       (s_q == S_RST_ON));

    // Two-flop synchroniser for the asynchronous PLL lock.
    always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
        lk_s1_q <= 1'b0;
        lk_s2_q <= 1'b0;
      end else begin
        lk_s1_q <= pll_locked_i[g];
        lk_s2_q <= lk_s1_q;
      end
    end

    // Next-state: lock loss > req drop > counter expiry.
    always_comb begin
      s_d    = s_q;
      cnt_d  = cnt_q;
      dly_d  = dly_q;
      to_d   = to_q;
      err_d  = err_q;
      lost_d = 1'b0;
      if (lock_drop) begin
        lost_d = 1'b1;
        if (req) begin
          s_d  = S_WAIT_LOCK;
          to_d = '0;
        end else begin
          s_d = S_OFF;
        end
      end else begin
        unique case (s_q)
          S_OFF: begin
            if (req && up_ok) begin
              s_d  = S_WAIT_LOCK;
              to_d = '0;
            end
          end
          S_WAIT_LOCK: begin
            if (!req) begin
              s_d = S_OFF;
            end else if (locked) begin
              s_d   = S_CLK_ON;
              dly_d = dly_eff;
              cnt_d = dly_eff;
            end else if (to_q == TO_LAST) begin
              s_d   = S_ERR;
              err_d = 1'b1;
            end else begin
              to_d = to_q + TO_W'(1);
            end
          end
          S_CLK_ON: begin
            if (!req) begin
              s_d   = S_RST_ON;
              cnt_d = dly_q;
            end else if (cnt_q == CNT_ONE) begin
              s_d = S_RUN;
            end else begin
              cnt_d = cnt_q - CNT_ONE;
            end
          end
          S_RUN: begin
            if (!req && down_ok) begin
              s_d   = S_RST_ON;
              cnt_d = dly_q;
            end
          end
          S_RST_ON: begin
            if (cnt_q == CNT_ONE) begin
              s_d = S_OFF;
            end else begin
              cnt_d = cnt_q - CNT_ONE;
            end
          end
          S_ERR: begin
            if (!req) begin
              s_d   = S_OFF;
              err_d = 1'b0;
            end
          end
          default: begin
            s_d   = S_OFF;
            err_d = 1'b0;
          end
        endcase
      end
    end

    // Domain state and outputs registered from next-state.
    always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
        s_q      <= S_OFF;
        cnt_q    <= '0;
        dly_q    <= '0;
        to_q     <= '0;
        err_q    <= 1'b0;
        lost_q   <= 1'b0;
        clk_en_q <= 1'b0;
        arst_n_q <= 1'b0;
      end else begin
        s_q      <= s_d;
        cnt_q    <= cnt_d;
        dly_q    <= dly_d;
        to_q     <= to_d;
        err_q    <= err_d;
        lost_q   <= lost_d;
        clk_en_q <= (s_d == S_CLK_ON) ||
                    (s_d == S_RUN) ||
                    (s_d == S_RST_ON);
        arst_n_q <= (s_d == S_RUN);
      end
    end

    assign busy_vec[g] = (s_d == S_WAIT_LOCK) ||
                         (s_d == S_CLK_ON) ||
                         (s_d == S_RST_ON);

    assign st_all[g*3 +: 3] = s_q;
    assign dom_clk_en_o[g]  = clk_en_q;
    assign dom_arst_n_o[g]  = arst_n_q;
    assign dom_err_o[g]     = err_q;
    assign lock_lost_o[g]   = lost_q;
  end

  // Busy flag registered alongside the domain states.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      busy_q <= 1'b0;
    end else begin
      busy_q <= |busy_vec;
    end
  end

  assign dom_state_o = st_all;
  assign busy_o      = busy_q;

endmodule
